// File: rtl/agex_muldiv_sequencer.sv
// agex_muldiv_sequencer: iterative RV32M unit that sits beside the AGEX ALU.
// Runs MUL/MULH/MULHSU/MULHU with shift-add and DIV/DIVU/REM/REMU with restoring division.
// It works on operand magnitudes and applies the sign correction once at completion.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_req_valid/op/a/b/tag: request from AGEX (op = funct3)
//   i_flush               : branch mispredict, aborts any operation in flight
//   o_req_ready           : high only when idle
//   o_stall               : freezes FE/DE/AGEX while a request is accepted or running
//   o_resp_valid          : one-cycle result pulse
//   o_resp_result/o_resp_tag: registered result and destination tag
module agex_muldiv_sequencer #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TAGBITS = 5,
    parameter int unsigned CNTBITS = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_req_valid,
    input  logic [2:0]         i_req_op,
    input  logic [XLEN-1:0]    i_req_a,
    input  logic [XLEN-1:0]    i_req_b,
    input  logic [TAGBITS-1:0] i_req_tag,
    input  logic               i_flush,
    output logic               o_req_ready,
    output logic               o_stall,
    output logic               o_resp_valid,
    output logic [XLEN-1:0]    o_resp_result,
    output logic [TAGBITS-1:0] o_resp_tag
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [CNTBITS-1:0] CntLast = CNTBITS'(XLEN - 1);
    localparam logic [XLEN-1:0]    MinInt  = {1'b1, {(XLEN-1){1'b0}}};

    state_e               r_state, w_state_d;
    logic [CNTBITS-1:0]   r_cnt;
    logic [2:0]           r_op;
    logic [TAGBITS-1:0]   r_tag;
    logic                 r_neg_q;   // product / quotient sign
    logic                 r_neg_r;   // remainder sign (sign of dividend)
    logic [XLEN-1:0]      r_a;       // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [XLEN-1:0]      r_b;       // multiplicand or divisor magnitude
    logic [XLEN-1:0]      r_hi;      // product high half or partial remainder
    logic [XLEN-1:0]      r_result;

    logic                 w_accept, w_last;
    logic                 w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN-1:0]      w_mag_a, w_mag_b;
    logic                 w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0]      w_special_res;
    logic [XLEN:0]        w_sum, w_shift;
    logic                 w_ge;
    logic [XLEN-1:0]      w_a_d, w_hi_d;
    logic [2*XLEN-1:0]    w_prod, w_prod_s;
    logic [XLEN-1:0]      w_quo_s, w_rem_s, w_final;

    assign w_accept = (r_state == StIdle) && i_req_valid && !i_flush;
    assign w_last   = (r_cnt == CntLast);

    // MUL's low half is sign-agnostic, so it simply shares the signed path.
    assign w_a_signed = !i_req_op[0] || (i_req_op == 3'd1);
    assign w_b_signed = (i_req_op == 3'd0) || (i_req_op == 3'd1) ||
                        (i_req_op == 3'd4) || (i_req_op == 3'd6);
    assign w_sa    = w_a_signed && i_req_a[XLEN-1];
    assign w_sb    = w_b_signed && i_req_b[XLEN-1];
    assign w_mag_a = w_sa ? -i_req_a : i_req_a;
    assign w_mag_b = w_sb ? -i_req_b : i_req_b;

    assign w_div_zero = i_req_op[2] && (i_req_b == '0);
    assign w_ovf      = ((i_req_op == 3'd4) || (i_req_op == 3'd6)) &&
                        (i_req_a == MinInt) && (i_req_b == '1);
    assign w_special  = w_div_zero || w_ovf;

    // op[1] selects REM/REMU among the divide ops.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = i_req_op[1] ? i_req_a : '1;
        end else if (w_ovf) begin
            w_special_res = i_req_op[1] ? '0 : i_req_a;
        end
    end

    // One iteration of either algorithm.
    assign w_sum   = {1'b0, r_hi} + {1'b0, (r_a[0] ? r_b : '0)};
    assign w_shift = {r_hi, r_a[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});

    always_comb begin
        w_a_d  = r_a;
        w_hi_d = r_hi;
        if (r_op[2]) begin
            w_hi_d = w_ge ? (w_shift[XLEN-1:0] - r_b) : w_shift[XLEN-1:0];
            w_a_d  = {r_a[XLEN-2:0], w_ge};
        end else begin
            w_hi_d = w_sum[XLEN:1];
            w_a_d  = {w_sum[0], r_a[XLEN-1:1]};
        end
    end

    // Sign correction applied to the values produced by the final iteration.
    assign w_prod   = {w_hi_d, w_a_d};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo_s  = r_neg_q ? -w_a_d : w_a_d;
    assign w_rem_s  = r_neg_r ? -w_hi_d : w_hi_d;

    always_comb begin
        w_final = '0;
        case (r_op)
            3'd0:             w_final = w_prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_final = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_final = w_quo_s;
            default:          w_final = w_rem_s;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_d = w_special ? StDone : StBusy;
            StBusy:  if (w_last) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (i_flush) begin
            w_state_d = StIdle;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_tag    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= i_req_op;
            r_tag   <= i_req_tag;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_hi    <= '0;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == StBusy && !i_flush) begin
            r_cnt <= r_cnt + CNTBITS'(1);
            r_a   <= w_a_d;
            r_hi  <= w_hi_d;
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    assign o_req_ready   = (r_state == StIdle);
    assign o_stall       = (r_state == StBusy) ||
                           ((r_state == StIdle) && i_req_valid && !i_flush);
    assign o_resp_valid  = (r_state == StDone);
    assign o_resp_result = r_result;
    assign o_resp_tag    = r_tag;

endmodule

// File: tb/tb_agex_muldiv_sequencer.sv
// tb_agex_muldiv_sequencer: directed vectors with a response scoreboard.
// The driver pushes {result, tag, cycle} on issue; a negedge monitor pops on every resp_valid.
module tb_agex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        req_ready, stall, resp_valid;
    logic [31:0] resp_result;
    logic [4:0]  resp_tag;

    agex_muldiv_sequencer #(.XLEN(32), .TAGBITS(5), .CNTBITS(6)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_req_valid(req_valid),
        .i_req_op(req_op),
        .i_req_a(req_a),
        .i_req_b(req_b),
        .i_req_tag(req_tag),
        .i_flush(flush),
        .o_req_ready(req_ready),
        .o_stall(stall),
        .o_resp_valid(resp_valid),
        .o_resp_result(resp_result),
        .o_resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            exp_t e;
            n_pulses++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got result %h tag %0d expected no response",
                         resp_result, resp_tag);
            end else begin
                e = sb.pop_front();
                check("resp_result", resp_result, e.res);
                check("resp_tag", 32'(resp_tag), 32'(e.tag));
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called right after a posedge with the DUT idle; holds req_valid for one cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] res, input int lat,
                         input bit expect_resp);
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        if (expect_resp) begin
            e.res = res;
            e.tag = tag;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        check({name, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int p0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_result", resp_result, 32'd0);
        check("rst_tag", 32'(resp_tag), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // MUL with full stall profile.
        n0 = cyc;
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd7; req_b = 32'hFFFF_FFFD; req_tag = 5'd5;
        begin
            exp_t e;
            e.res = 32'hFFFF_FFEB; e.tag = 5'd5; e.cyc = n0 + 33;
            sb.push_back(e);
        end
        @(negedge clk);
        check("mul_stall_accept", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            check("mul_stall", 32'(stall), (k < 33) ? 32'd1 : 32'd0);
        end
        wait_done("mul");

        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33, 1'b1);
        wait_done("mulh");
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, 1'b1);
        wait_done("mulhu");
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 33, 1'b1);
        wait_done("mulhsu");
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33, 1'b1);
        wait_done("div");
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 1'b1);
        wait_done("rem");
        issue(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1'b1);
        wait_done("divu");
        issue(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33, 1'b1);
        wait_done("remu");

        // Special cases resolve in one cycle.
        issue(3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1, 1'b1);
        wait_done("divu_by0");
        issue(3'd6, 32'd5, 32'd0, 5'd12, 32'd5, 1, 1'b1);
        wait_done("rem_by0");
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, 1'b1);
        wait_done("div_ovf");
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1, 1'b1);
        wait_done("rem_ovf");

        // Flush at BUSY iteration 10.
        p0 = n_pulses;
        issue(3'd4, 32'd1000, 32'd3, 5'd15, 32'd0, 0, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_ready", 32'(req_ready), 32'd1);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("flush_no_pulse", 32'(n_pulses), 32'(p0));
        issue(3'd0, 32'd3, 32'd4, 5'd16, 32'd12, 33, 1'b1);
        wait_done("mul_after_flush");

        // Back-to-back with req_valid held: second accept lands at N+34.
        n0 = cyc;
        req_valid = 1'b1; req_op = 3'd3; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
        req_tag = 5'd9;
        begin
            exp_t e;
            e.res = 32'hFFFF_FFFE; e.tag = 5'd9; e.cyc = n0 + 33;
            sb.push_back(e);
            e.res = 32'd14; e.tag = 5'd10; e.cyc = n0 + 67;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_op = 3'd5; req_a = 32'd100; req_b = 32'd7; req_tag = 5'd10;
        repeat (32) begin
            @(posedge clk);
            #1;
        end
        check("b2b_done_stall", 32'(stall), 32'd0);
        check("b2b_done_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("b2b_idle_ready", 32'(req_ready), 32'd1);
        check("b2b_idle_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b_second_busy", 32'(stall), 32'd1);
        wait_done("b2b");

        // Reset at BUSY iteration 20.
        p0 = n_pulses;
        issue(3'd7, 32'd100, 32'd7, 5'd21, 32'd0, 0, 1'b0);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_valid", 32'(resp_valid), 32'd0);
        check("midrst_result", resp_result, 32'd0);
        check("midrst_tag", 32'(resp_tag), 32'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("midrst_no_pulse", 32'(n_pulses), 32'(p0));
        issue(3'd7, 32'd100, 32'd7, 5'd22, 32'd2, 33, 1'b1);
        wait_done("remu_after_rst");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/agex_muldiv_sequencer.md
Name: agex_muldiv_sequencer

Overview:
- Multi-cycle M-extension unit beside the AGEX ALU. Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU iteratively.
- Owns the FSM that accepts one request from AGEX and stalls the front of the pipeline while busy.
- Returns a single-cycle result pulse that AGEX muxes into aluout in place of the ALU result.
- A branch-mispredict flush aborts any operation in flight.

Parameters:
- XLEN, 32, operand/result width
- TAGBITS, 5, width of the destination-register tag carried with the request
- CNTBITS, 6, iteration counter width; must satisfy 2^CNTBITS > XLEN

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  AGEX holds a valid M-extension instruction
- req_op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_a  input  XLEN  rs1 value
- req_b  input  XLEN  rs2 value
- req_tag  input  TAGBITS  wregno of the instruction
- flush  input  1  br_mispred from AGEX; kills the operation in flight
- req_ready  output  1  high only in IDLE
- stall  output  1  freeze FE/DE/AGEX latches
- resp_valid  output  1  one-cycle result pulse
- resp_result  output  XLEN  final result
- resp_tag  output  TAGBITS  tag of the completed request

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, counter=0, resp_valid=0, resp_result=0, resp_tag=0; stall=0 and req_ready=1 after reset.
- States and transitions:
  - IDLE: if req_valid && !flush, accept the request. Latch op and tag, convert signed operands to magnitudes, record the result sign.
  - IDLE, special-case accept: divide-by-zero or signed overflow goes to DONE. All other accepts go to BUSY with counter=0.
  - BUSY: one iteration per cycle for exactly XLEN cycles; go to DONE when counter==XLEN-1.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
- Multiply: radix-2 shift-add on magnitudes into a 2*XLEN accumulator.
  - Apply two's-complement negation of the full 2*XLEN product if the result sign is set.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - MULHSU treats only rs1 as signed.
- Divide: restoring algorithm on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Divide special cases, resolved at accept with no BUSY cycles:
  - b==0: quotient=all ones, remainder=a.
  - Signed a==0x80000000 with b==0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Final sign correction happens on the BUSY->DONE edge. resp_result is registered and stable throughout DONE.
- Latency:
  - Accept in cycle N: normal ops pulse resp_valid in cycle N+XLEN+1 (N+33); special cases pulse in N+1.
  - No new request is accepted in DONE, so back-to-back accepts are at least 34 cycles apart.
- stall = (state==BUSY) || (state==IDLE && req_valid && !flush). It is combinational and deasserts in DONE, so AGEX captures resp_result that cycle.
- Flush:
  - Flush in any state forces IDLE next cycle; resp_valid stays 0 and no tag is reported.
  - Flush in the same cycle as req_valid in IDLE means no accept.
  - Flush in DONE does not cancel the current pulse, because the instruction is already committed to the AGEX latch.
- Reset mid-operation: returns to IDLE next cycle with all outputs at reset values.
- Non-M ops never reach this block; AGEX gates req_valid.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, tag=5, accept cycle N -> resp_valid only in N+33, resp_result=0xFFFFFFEB, resp_tag=5; stall high N..N+32, low N+33.
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2; each with 33-cycle latency.
- DIVU a=5, b=0 -> resp_result 0xFFFFFFFF at N+1; REM a=5, b=0 -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at N+1; REM of the same operands -> 0.
- Accept DIV, assert flush at BUSY cycle 10 -> IDLE next cycle, no resp_valid, stall low. Then a new MUL 3*4 with req_valid held -> 12 after 33 cycles.
- Hold req_valid continuously with two different ops -> second accepted exactly at DONE+1 (N+34). Reset asserted at BUSY cycle 20 -> outputs zeroed, req_ready=1 next cycle.
